// File: rtl/arf_ctrl_pkg.sv
// Shared encodings for the PC/AR/SP address register file sequencer:
// command codes, ARF select/function codes, FSM states and the per-step output bundle.
package arf_ctrl_pkg;

    localparam logic [2:0] CMD_NOP   = 3'b000;
    localparam logic [2:0] CMD_FETCH = 3'b001;
    localparam logic [2:0] CMD_JUMP  = 3'b010;
    localparam logic [2:0] CMD_LDAR  = 3'b011;
    localparam logic [2:0] CMD_PUSH  = 3'b100;
    localparam logic [2:0] CMD_POP   = 3'b101;
    localparam logic [2:0] CMD_CALL  = 3'b110;
    localparam logic [2:0] CMD_RET   = 3'b111;

    localparam logic [2:0] FS_DEC  = 3'b000;
    localparam logic [2:0] FS_INC  = 3'b001;
    localparam logic [2:0] FS_LOAD = 3'b010;

    // RegSel enables are active-low, one register per bit
    localparam logic [2:0] REGSEL_NONE = 3'b111;
    localparam logic [2:0] REGSEL_PC   = 3'b011;
    localparam logic [2:0] REGSEL_AR   = 3'b101;
    localparam logic [2:0] REGSEL_SP   = 3'b110;

    localparam logic [1:0] OSEL_PC = 2'b00;
    localparam logic [1:0] OSEL_AR = 2'b10;
    localparam logic [1:0] OSEL_SP = 2'b11;

    typedef enum logic [2:0] {IDLE, S1, S2, S3, FAULT} state_t;

    typedef struct packed {
        logic [2:0] funsel;
        logic [2:0] regsel;
        logic [1:0] outcsel;
        logic [1:0] outdsel;
        logic       memrd;
        logic       memwr;
        logic       done;
    } step_t;

    localparam step_t STEP_IDLE = '{
        funsel: FS_DEC, regsel: REGSEL_NONE, outcsel: OSEL_PC, outdsel: OSEL_PC,
        memrd: 1'b0, memwr: 1'b0, done: 1'b0
    };

    function automatic logic [1:0] cmd_steps(input logic [2:0] cmd);
        case (cmd)
            CMD_FETCH, CMD_PUSH, CMD_POP: cmd_steps = 2'd2;
            CMD_CALL, CMD_RET:            cmd_steps = 2'd3;
            default:                      cmd_steps = 2'd1;
        endcase
    endfunction

endpackage

// File: rtl/arf_sequencer.sv
// Command sequencer for the PC/AR/SP register file: expands one command into 1-3 steps.
// Optional stack over/underflow guard enabled by defining ARF_STACK_GUARD_EN.
module arf_sequencer
`ifdef ARF_STACK_GUARD_EN
#(
    parameter logic [15:0] STACK_LIMIT = 16'h0000,
    parameter logic [15:0] STACK_BASE  = 16'hFFFF
)
`endif
(
    input  logic        Clock,
    input  logic        Reset,
    input  logic        CmdValid,
    input  logic [2:0]  Cmd,
    output logic        CmdReady,
    output logic        Done,
    output logic [2:0]  FunSel,
    output logic [2:0]  RegSel,
    output logic [1:0]  OutCSel,
    output logic [1:0]  OutDSel,
    output logic        MemRd,
    output logic        MemWr
`ifdef ARF_STACK_GUARD_EN
    ,
    input  logic [15:0] SpQ,
    output logic        StackFault
`endif
);
    import arf_ctrl_pkg::*;

    state_t     state, state_n;
    logic [2:0] cmd_q, cmd_n;
    logic       ready_q;
    logic       accept;
    logic       fault;
    step_t      step_q;

    function automatic step_t decode_step(input state_t st, input logic [2:0] cmd);
        step_t s;
        s = STEP_IDLE;
        case (st)
            S1: case (cmd)
                CMD_NOP:   s.done = 1'b1;
                CMD_FETCH: begin s.outdsel = OSEL_PC; s.memrd = 1'b1; end
                CMD_JUMP:  begin s.regsel = REGSEL_PC; s.funsel = FS_LOAD; s.done = 1'b1; end
                CMD_LDAR:  begin s.regsel = REGSEL_AR; s.funsel = FS_LOAD; s.done = 1'b1; end
                CMD_PUSH, CMD_CALL: begin s.regsel = REGSEL_SP; s.funsel = FS_DEC; end
                default:   begin s.outdsel = OSEL_SP; s.memrd = 1'b1; end
            endcase
            S2: case (cmd)
                CMD_FETCH: begin s.regsel = REGSEL_PC; s.funsel = FS_INC; s.done = 1'b1; end
                CMD_PUSH:  begin s.outdsel = OSEL_SP; s.memwr = 1'b1; s.done = 1'b1; end
                CMD_POP:   begin s.regsel = REGSEL_SP; s.funsel = FS_INC; s.done = 1'b1; end
                CMD_CALL:  begin s.outdsel = OSEL_SP; s.outcsel = OSEL_PC; s.memwr = 1'b1; end
                CMD_RET:   begin s.regsel = REGSEL_SP; s.funsel = FS_INC; end
                default:   s = STEP_IDLE;
            endcase
            // Third step of CALL/RET loads the new PC from the immediate
            S3:      begin s.regsel = REGSEL_PC; s.funsel = FS_LOAD; s.done = 1'b1; end
            FAULT:   s.done = 1'b1;
            default: s = STEP_IDLE;
        endcase
        return s;
    endfunction

    always_comb begin
        accept = CmdValid && ready_q;
`ifdef ARF_STACK_GUARD_EN
        fault = ((Cmd == CMD_PUSH || Cmd == CMD_CALL) && SpQ == STACK_LIMIT) ||
                ((Cmd == CMD_POP  || Cmd == CMD_RET)  && SpQ == STACK_BASE);
`else
        fault = 1'b0;
`endif
        cmd_n   = accept ? Cmd : cmd_q;
        state_n = state;
        case (state)
            IDLE:    if (accept) state_n = fault ? FAULT : S1;
            S1:      state_n = (cmd_steps(cmd_q) == 2'd1) ? IDLE : S2;
            S2:      state_n = (cmd_steps(cmd_q) == 2'd2) ? IDLE : S3;
            default: state_n = IDLE;
        endcase
    end

    // Outputs are registered from the next state so every output is a pure state decode
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            state   <= IDLE;
            cmd_q   <= CMD_NOP;
            ready_q <= 1'b1;
            step_q  <= STEP_IDLE;
`ifdef ARF_STACK_GUARD_EN
            StackFault <= 1'b0;
`endif
        end else begin
            state   <= state_n;
            cmd_q   <= cmd_n;
            ready_q <= (state_n == IDLE);
            step_q  <= decode_step(state_n, cmd_n);
`ifdef ARF_STACK_GUARD_EN
            StackFault <= (state_n == FAULT);
`endif
        end
    end

    assign CmdReady = ready_q;
    assign Done     = step_q.done;
    assign FunSel   = step_q.funsel;
    assign RegSel   = step_q.regsel;
    assign OutCSel  = step_q.outcsel;
    assign OutDSel  = step_q.outdsel;
    assign MemRd    = step_q.memrd;
    assign MemWr    = step_q.memwr;

endmodule

// File: tb/tb_arf_sequencer.sv
// Self-checking bench for arf_sequencer: a register-file/memory model driven by the DUT
// strobes, checked against an architectural model of each command's effect.
module tb_arf_sequencer;

    logic        Clock = 1'b0;
    logic        Reset;
    logic        CmdValid;
    logic [2:0]  Cmd;
    logic        CmdReady, Done, MemRd, MemWr;
    logic [2:0]  FunSel, RegSel;
    logic [1:0]  OutCSel, OutDSel;
`ifdef ARF_STACK_GUARD_EN
    logic        StackFault;
`endif

    // register file + memory reacting to DUT strobes
    logic [15:0] pc, ar, sp, imm, rd_data;
    logic [15:0] mem [0:65535];
    logic        pre_en;
    logic [15:0] pre_pc, pre_ar, pre_sp;

    // architectural model
    logic [15:0] m_pc, m_ar, m_sp;
    logic [15:0] m_mem [logic [15:0]];

    int checks = 0;
    int errors = 0;

    always #5 Clock = ~Clock;

    arf_sequencer dut (
        .Clock(Clock), .Reset(Reset), .CmdValid(CmdValid), .Cmd(Cmd),
        .CmdReady(CmdReady), .Done(Done), .FunSel(FunSel), .RegSel(RegSel),
        .OutCSel(OutCSel), .OutDSel(OutDSel), .MemRd(MemRd), .MemWr(MemWr)
`ifdef ARF_STACK_GUARD_EN
        , .SpQ(sp), .StackFault(StackFault)
`endif
    );

    function automatic logic [15:0] osel(input logic [1:0] s);
        case (s)
            2'b00:   return pc;
            2'b10:   return ar;
            2'b11:   return sp;
            default: return 16'hxxxx;
        endcase
    endfunction

    function automatic logic [15:0] alu(input logic [15:0] v, input logic [2:0] fs);
        case (fs)
            3'b000:  return v - 16'd1;
            3'b001:  return v + 16'd1;
            3'b010:  return imm;
            default: return v;
        endcase
    endfunction

    always @(posedge Clock) begin
        if (pre_en) begin
            pc <= pre_pc; ar <= pre_ar; sp <= pre_sp;
        end else begin
            if (RegSel[2] === 1'b0) pc <= alu(pc, FunSel);
            if (RegSel[1] === 1'b0) ar <= alu(ar, FunSel);
            if (RegSel[0] === 1'b0) sp <= alu(sp, FunSel);
            if (MemWr === 1'b1) mem[osel(OutDSel)] <= osel(OutCSel);
            if (MemRd === 1'b1) rd_data <= mem[osel(OutDSel)];
        end
    end

    // expected {FunSel,RegSel,OutCSel,OutDSel,MemRd,MemWr,Done} for step k of a command
    function automatic logic [12:0] exp_step(input logic [2:0] c, input int k);
        logic [12:0] t [8][3];
        t[0] = '{13'b000_111_00_00_001, 13'h0, 13'h0};
        t[1] = '{13'b000_111_00_00_100, 13'b001_011_00_00_001, 13'h0};
        t[2] = '{13'b010_011_00_00_001, 13'h0, 13'h0};
        t[3] = '{13'b010_101_00_00_001, 13'h0, 13'h0};
        t[4] = '{13'b000_110_00_00_000, 13'b000_111_00_11_011, 13'h0};
        t[5] = '{13'b000_111_00_11_100, 13'b001_110_00_00_001, 13'h0};
        t[6] = '{13'b000_110_00_00_000, 13'b000_111_00_11_010, 13'b010_011_00_00_001};
        t[7] = '{13'b000_111_00_11_100, 13'b001_110_00_00_000, 13'b010_011_00_00_001};
        return t[c][k];
    endfunction

    function automatic int nsteps(input logic [2:0] c);
        int n [8] = '{1, 2, 1, 1, 2, 2, 3, 3};
        return n[c];
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [12:0] outs();
        return {FunSel, RegSel, OutCSel, OutDSel, MemRd, MemWr, Done};
    endfunction

    task automatic preset(input logic [15:0] p, input logic [15:0] a, input logic [15:0] s);
        pre_pc = p; pre_ar = a; pre_sp = s; pre_en = 1'b1;
        @(negedge Clock);
        pre_en = 1'b0;
        m_pc = p; m_ar = a; m_sp = s;
    endtask

    task automatic run_cmd(input logic [2:0] c, input logic [15:0] i);
        int n = 0;
        bit flt = 1'b0;
        logic [15:0] old_sp;
        while (CmdReady !== 1'b1 && n < 20) begin @(negedge Clock); n++; end
        check("ready_before_cmd", CmdReady, 1'b1);
`ifdef ARF_STACK_GUARD_EN
        flt = ((c == 3'd4 || c == 3'd6) && m_sp == 16'h0000) ||
              ((c == 3'd5 || c == 3'd7) && m_sp == 16'hFFFF);
`endif
        imm = i; CmdValid = 1'b1; Cmd = c;
        @(negedge Clock);
        CmdValid = 1'b0; Cmd = 3'($urandom);
        if (flt) begin
            check($sformatf("fault_step cmd%0d", c), outs(), 13'b000_111_00_00_001);
`ifdef ARF_STACK_GUARD_EN
            check("stackfault_pulse", StackFault, 1'b1);
`endif
            @(negedge Clock);
        end else begin
            for (int k = 0; k < nsteps(c); k++) begin
                check($sformatf("step cmd%0d s%0d", c, k + 1), outs(), exp_step(c, k));
                check($sformatf("busy cmd%0d s%0d", c, k + 1), CmdReady, 1'b0);
`ifdef ARF_STACK_GUARD_EN
                check("stackfault_quiet", StackFault, 1'b0);
`endif
                @(negedge Clock);
            end
            old_sp = m_sp;
            case (c)
                3'd1: m_pc = m_pc + 16'd1;
                3'd2: m_pc = i;
                3'd3: m_ar = i;
                3'd4: begin m_sp = m_sp - 16'd1; m_mem[m_sp] = m_pc; end
                3'd5: m_sp = m_sp + 16'd1;
                3'd6: begin m_sp = m_sp - 16'd1; m_mem[m_sp] = m_pc; m_pc = i; end
                3'd7: begin m_sp = m_sp + 16'd1; m_pc = i; end
                default: ;
            endcase
            if (c == 3'd4 || c == 3'd6) check("pushed_word", mem[m_sp], m_mem[m_sp]);
            if ((c == 3'd5 || c == 3'd7) && m_mem.exists(old_sp))
                check("popped_word", rd_data, m_mem[old_sp]);
        end
        check("idle_after_cmd", {CmdReady, Done}, 2'b10);
        check("pc", pc, m_pc);
        check("ar", ar, m_ar);
        check("sp", sp, m_sp);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        Reset = 1'b0; CmdValid = 1'b0; Cmd = 3'd0; imm = 16'h0; pre_en = 1'b1;
        pre_pc = 16'h0; pre_ar = 16'h0; pre_sp = 16'h0;
        repeat (2) @(negedge Clock);
        check("reset_outputs", outs(), 13'b000_111_00_00_000);
        check("reset_ready", CmdReady, 1'b1);
        Reset = 1'b1;
        preset(16'h0010, 16'h0000, 16'h0100);

        run_cmd(3'd1, 16'h0);          // FETCH: PC 0010 -> 0011
        check("fetch_pc", pc, 16'h0011);
        run_cmd(3'd4, 16'h0);          // PUSH
        check("push_sp", sp, 16'h00FF);
        check("push_mem", mem[16'h00FF], 16'h0011);
        run_cmd(3'd5, 16'h0);          // POP
        check("pop_sp", sp, 16'h0100);

        preset(16'h0040, m_ar, 16'h0100);
        run_cmd(3'd6, 16'h0200);       // CALL
        check("call_mem", mem[16'h00FF], 16'h0040);
        check("call_pc", pc, 16'h0200);
        run_cmd(3'd7, 16'h0040);       // RET
        check("ret_pc_sp", {pc, sp}, {16'h0040, 16'h0100});
        check("ret_read", rd_data, 16'h0040);

        // back-to-back with CmdValid held high; busy-time Cmd change must not disturb JUMP
        imm = 16'h0300; CmdValid = 1'b1; Cmd = 3'd2;
        @(negedge Clock);
        check("b2b_jump_step", outs(), 13'b010_011_00_00_001);
        Cmd = 3'd3;
        @(negedge Clock);
        check("b2b_gap", {CmdReady, Done}, 2'b10);
        check("b2b_jump_pc", pc, 16'h0300);
        imm = 16'h0500;
        @(negedge Clock);
        check("b2b_ldar_step", outs(), 13'b010_101_00_00_001);
        CmdValid = 1'b0;
        @(negedge Clock);
        check("b2b_ldar_ar", ar, 16'h0500);
        check("b2b_pc_kept", pc, 16'h0300);
        m_pc = 16'h0300; m_ar = 16'h0500;

        // reset in CALL step 2 aborts the PC load
        preset(16'h1234, m_ar, 16'h0100);
        imm = 16'hBEEF; CmdValid = 1'b1; Cmd = 3'd6;
        @(negedge Clock);
        CmdValid = 1'b0;
        @(negedge Clock);
        check("abort_at_s2", outs(), 13'b000_111_00_11_010);
        Reset = 1'b0;
        @(negedge Clock);
        Reset = 1'b1;
        check("abort_outputs", {RegSel, MemWr, CmdReady}, {3'b111, 1'b0, 1'b1});
        @(negedge Clock);
        check("abort_sp_pc", {sp, pc}, {16'h00FF, 16'h1234});
        check("abort_idle", outs(), 13'b000_111_00_00_000);
        m_sp = 16'h00FF; m_pc = 16'h1234; m_mem[16'h00FF] = 16'h1234;

        // stack boundaries: refused in the guard build, wrap otherwise
        preset(16'h0777, m_ar, 16'h0000);
        run_cmd(3'd4, 16'h0);
        preset(16'h0777, m_ar, 16'hFFFF);
        run_cmd(3'd7, 16'h0123);

        preset(16'h0100, 16'h0, 16'h8000);
        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 3) == 0) @(negedge Clock);
            run_cmd(3'($urandom_range(0, 7)), 16'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
